// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX FCS inserter.
// Build option: define ETH_TX_PAD_EN to compile in short-frame padding.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_PAD  = 3'd2,
    ST_FCS  = 3'd3,
    ST_IFG  = 3'd4
  } tx_state_e;

  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam int          FCS_BYTES       = 4;
  localparam int          DEF_MIN_PAYLOAD = 60;
  localparam int          DEF_IFG_BYTES   = 12;
  localparam logic [10:0] BYTE_CNT_MAX    = 11'h7FF;

  // Byte counter increment that sticks at its maximum.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == BYTE_CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_crc32_d8.sv
// Combinational CRC-32 (reflected) next-state for one byte, LSB first.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight serial shift steps unrolled into one cycle.
  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX framer: passes payload through, optionally pads, appends FCS, enforces IFG.
// Build option: ETH_TX_PAD_EN enables padding of short frames up to MIN_PAYLOAD bytes.
module eth_tx_fcs_ctrl
  import eth_tx_pkg::*;
#(
  parameter int IFG_BYTES   = DEF_IFG_BYTES,
  parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [15:0] frame_count
);

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_e   state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [10:0] byte_cnt;
  logic [10:0] cnt_next;
  logic [1:0]  fcs_idx;
  logic [7:0]  ifg_cnt;
  logic [7:0]  crc_data;

  assign crc_data = (state == ST_PAD) ? 8'h00 : in_data;
  assign cnt_next = sat_inc(byte_cnt);
  assign fcs_word = ~crc;

  crc32_d8 u_crc (
    .data    (crc_data),
    .crc_in  (crc),
    .crc_out (crc_next)
  );

  // Output/handshake steering; payload is a zero-latency pass-through.
  always_comb begin
    in_ready  = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        in_ready  = out_ready & ~reset;
        out_data  = in_data;
        out_valid = in_valid & ~reset;
      end
      ST_PAD: begin
        out_valid = ~reset;
      end
      ST_FCS: begin
        out_valid = ~reset;
        out_last  = (fcs_idx == 2'd3) & ~reset;
        case (fcs_idx)
          2'd0:    out_data = fcs_word[7:0];
          2'd1:    out_data = fcs_word[15:8];
          2'd2:    out_data = fcs_word[23:16];
          2'd3:    out_data = fcs_word[31:24];
          default: out_data = 8'h00;
        endcase
      end
      ST_IFG: begin
        out_valid = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Frame sequencing, CRC accumulation and frame statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      crc         <= CRC_INIT;
      byte_cnt    <= 11'd0;
      fcs_idx     <= 2'd0;
      ifg_cnt     <= 8'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DATA: begin
          if (in_valid && out_ready) begin
            crc      <= crc_next;
            byte_cnt <= cnt_next;
            fcs_idx  <= 2'd0;
            if (in_last) begin
              state <= (PAD_EN && (cnt_next < MIN_CNT)) ? ST_PAD : ST_FCS;
            end else begin
              state <= ST_DATA;
            end
          end
        end
`ifdef ETH_TX_PAD_EN
        ST_PAD: begin
          if (out_ready) begin
            crc      <= crc_next;
            byte_cnt <= cnt_next;
            if (cnt_next >= MIN_CNT) begin
              state <= ST_FCS;
            end
          end
        end
`endif
        ST_FCS: begin
          if (out_ready) begin
            fcs_idx <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              state       <= ST_IFG;
              ifg_cnt     <= 8'd0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
          end
        end
        ST_IFG: begin
          if (ifg_cnt == IFG_LAST) begin
            state    <= ST_IDLE;
            crc      <= CRC_INIT;
            byte_cnt <= 11'd0;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Self-checking bench for eth_tx_fcs_ctrl against a behavioural frame model.
module tb_eth_tx_fcs_ctrl;

  localparam int IFG  = 12;
  localparam int MINP = 60;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;
  logic [15:0] frame_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  eth_tx_fcs_ctrl #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-reflected CRC-32 on LSB-first bit stream, output reflected and inverted.
  function automatic logic [31:0] model_fcs(input byte unsigned q[$]);
    logic [31:0] r;
    logic [31:0] o;
    logic        fb;
    r = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[31] ^ q[k][i];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return ~o;
  endfunction

  function automatic void model_frame(input byte unsigned pl[$], output byte unsigned ex[$]);
    logic [31:0] f;
    ex = pl;
    if (PAD) while (ex.size() < MINP) ex.push_back(8'h00);
    f = model_fcs(ex);
    for (int i = 0; i < 4; i++) ex.push_back(f[8*i +: 8]);
  endfunction

  task automatic send_frame(input byte unsigned pl[$], input bit rnd, input string tag,
                            input int exp_count, input int exp_total,
                            input bit use_const, input logic [31:0] fcs_const);
    byte unsigned got[$];
    byte unsigned ex[$];
    int idx = 0, cyc = 0, mism = 0, unstable = 0, last_pos = -1, fd_early = 0;
    int gaps = 0, ovb = 0, fd_extra = 0;
    bit done = 1'b0, stall_prev = 1'b0, seen_idle = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [31:0] tail;
    model_frame(pl, ex);
    while (!done && cyc < 5000) begin
      @(negedge clk);
      in_valid  = (idx < pl.size()) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
      in_data   = in_valid ? pl[idx] : 8'($urandom);
      in_last   = in_valid ? (idx == pl.size() - 1) : 1'($urandom_range(0, 1));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (frame_done) fd_early++;
      if (stall_prev && out_valid && (out_data !== prev_data || out_last !== prev_last)) unstable++;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          last_pos = got.size();
          done     = 1'b1;
        end
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " byte total"}, 32'(got.size()), 32'(exp_total));
    for (int i = 0; i < got.size() && i < ex.size(); i++) if (got[i] !== ex[i]) mism++;
    check({tag, " byte mismatches"}, 32'(mism), 32'd0);
    check({tag, " out_last position"}, 32'(last_pos), 32'(ex.size()));
    check({tag, " stall stability errors"}, 32'(unstable), 32'd0);
    check({tag, " early frame_done"}, 32'(fd_early), 32'd0);
    if (use_const && got.size() >= 4) begin
      tail = {got[got.size()-1], got[got.size()-2], got[got.size()-3], got[got.size()-4]};
      check({tag, " fcs"}, tail, fcs_const);
    end
    for (int k = 0; k < 300 && !seen_idle; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1;
      if (k == 0) begin
        check({tag, " frame_done pulse"}, 32'(frame_done), 32'd1);
        check({tag, " frame_count"}, 32'(frame_count), 32'(exp_count));
      end else if (frame_done) begin
        fd_extra++;
      end
      if (in_ready) seen_idle = 1'b1;
      else begin
        gaps++;
        if (out_valid) ovb++;
      end
    end
    check({tag, " ifg length"}, 32'(gaps), 32'(IFG));
    check({tag, " ifg valid/extra pulses"}, 32'(ovb + fd_extra), 32'd0);
  endtask

  typedef struct {
    int          kind;      // 0 ascii, 1 incrementing, 2 random, 3 single 0x55, 4 reuse last
    int          len;
    bit          rnd;
    int          exp_total;
    bit          use_const;
    logic [31:0] fcs_const;
  } vec_t;

  vec_t tbl[7];

  initial begin
    byte unsigned pl[$];
    byte unsigned ascii[$];
    byte unsigned tmp[$];
    int idx;
    for (int i = 0; i < 9; i++) ascii.push_back(8'h31 + 8'(i));
    tbl[0] = '{0,   9, 1'b0, PAD ? 64 : 13,  !PAD, 32'hCBF43926};
    tbl[1] = '{3,   1, 1'b0, PAD ? 64 : 5,   1'b0, 32'h0};
    tbl[2] = '{2, 100, 1'b0, 104,            1'b0, 32'h0};
    tbl[3] = '{4, 100, 1'b1, 104,            1'b0, 32'h0};
    tbl[4] = '{1,  60, 1'b0, 64,             1'b0, 32'h0};
    tbl[5] = '{2, 300, 1'b1, 304,            1'b0, 32'h0};
    tbl[6] = '{2,  59, 1'b1, PAD ? 64 : 63,  1'b0, 32'h0};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b1;
    #1;
    check("idle in_ready", 32'(in_ready), 32'd1);
    check("idle in_last ignored", 32'(out_valid), 32'd0);

    for (int r = 0; r < 7; r++) begin
      if (tbl[r].kind != 4) pl.delete();
      case (tbl[r].kind)
        0: pl = ascii;
        1: for (int i = 0; i < tbl[r].len; i++) pl.push_back(8'(i));
        2: for (int i = 0; i < tbl[r].len; i++) pl.push_back(8'($urandom));
        3: pl.push_back(8'h55);
        default: ;
      endcase
      send_frame(pl, tbl[r].rnd, $sformatf("vec%0d", r), r + 1,
                 tbl[r].exp_total, tbl[r].use_const, tbl[r].fcs_const);
    end

    // Abort a frame with reset after 20 accepted payload bytes.
    tmp.delete();
    for (int i = 0; i < 40; i++) tmp.push_back(8'($urandom));
    idx = 0;
    for (int k = 0; k < 200 && idx < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = tmp[idx]; in_last = 1'b0; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) idx++;
    end
    check("abort reached byte 20", 32'(idx), 32'd20);
    @(negedge clk);
    reset = 1'b1; in_data = tmp[idx];
    #1;
    check("abort in_ready during reset", 32'(in_ready), 32'd0);
    check("abort out_valid during reset", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b1;
    #1;
    check("abort out_valid after", 32'(out_valid), 32'd0);
    check("abort frame_done", 32'(frame_done), 32'd0);
    check("abort frame_count", 32'(frame_count), 32'd0);
    check("abort idle in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("abort stays idle", 32'({out_valid, frame_done}), 32'd0);

    send_frame(ascii, 1'b0, "post-abort ascii", 1, PAD ? 64 : 13, !PAD, 32'hCBF43926);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
